// File: rtl/alu_issue.sv
// Issue/writeback stage in front of the single-cycle ALU: decodes one instruction at a
// time, reads operands from an 8-entry register file, pulses the ALU and commits its result.
module alu_issue #(
  parameter int unsigned DWIDTH  = 16,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic              alu_en,
  output logic [2:0]        alu_func,
  output logic [DWIDTH-1:0] alu_a,
  output logic [DWIDTH-1:0] alu_b,
  output logic [DWIDTH-1:0] alu_imm,
  input  logic [DWIDTH-1:0] alu_res,
  input  logic              alu_res_en,
  output logic              retire,
  output logic              busy,
  output logic              timeout_err,
  input  logic [2:0]        dbg_addr,
  output logic [DWIDTH-1:0] dbg_data
);

  localparam int unsigned IMM_W = 7;
  localparam int unsigned RA_W  = 3;
  localparam int unsigned NREG  = 8;
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Decoded view of the instruction word; rs2 and imm share bits [6:4].
  typedef struct packed {
    logic [2:0]       func;
    logic [RA_W-1:0]  rd;
    logic [RA_W-1:0]  rs1;
    logic [RA_W-1:0]  rs2;
    logic [IMM_W-1:0] imm;
  } dec_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [RA_W-1:0]   rd_q;
  logic [DWIDTH-1:0] rf [NREG];

  dec_t              dec;
  logic [DWIDTH-1:0] rs1_val;
  logic [DWIDTH-1:0] rs2_val;
  logic [DWIDTH-1:0] imm_sext;
  logic              accept;
  logic              wb;
  logic              expire;

  assign dec.func = instr[15:13];
  assign dec.rd   = instr[12:10];
  assign dec.rs1  = instr[9:7];
  assign dec.rs2  = instr[6:4];
  assign dec.imm  = instr[6:0];

  // r0 is hardwired to zero on every read port.
  assign rs1_val  = (dec.rs1 == '0) ? '0 : rf[dec.rs1];
  assign rs2_val  = (dec.rs2 == '0) ? '0 : rf[dec.rs2];
  assign dbg_data = (dbg_addr == '0) ? '0 : rf[dbg_addr];
  assign imm_sext = {{(DWIDTH - IMM_W){dec.imm[IMM_W-1]}}, dec.imm};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a result arriving on the last wait cycle beats the timeout.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (instr_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (alu_res_en || (cnt == CNT_LAST)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state actions feeding the registered outputs and datapath.
  always_comb begin
    accept  = 1'b0;
    wb      = 1'b0;
    expire  = 1'b0;
    cnt_nxt = cnt;
    unique case (state)
      IDLE:  accept = instr_valid;
      ISSUE: cnt_nxt = '0;
      WAIT: begin
        if (alu_res_en) begin
          wb = 1'b1;
        end else if (cnt == CNT_LAST) begin
          expire = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Control outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      instr_ready <= 1'b1;
      busy        <= 1'b0;
      alu_en      <= 1'b0;
      retire      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      instr_ready <= (state_nxt == IDLE);
      busy        <= (state_nxt != IDLE);
      alu_en      <= (state_nxt == ISSUE);
      retire      <= wb;
      if (expire) timeout_err <= 1'b1;
    end
  end

  // Operand capture on acceptance; held until the next accepted instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_func <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_imm  <= '0;
      rd_q     <= '0;
    end else if (accept) begin
      alu_func <= dec.func;
      alu_a    <= rs1_val;
      alu_b    <= rs2_val;
      alu_imm  <= imm_sext;
      rd_q     <= dec.rd;
    end
  end

  // Register file write-back; writes to r0 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb && (rd_q != '0)) begin
      rf[rd_q] <= alu_res;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: a vector table run through a single-cycle ALU model,
// plus hand sequences for back-to-back issue, timeout, result/timeout race and reset.
module tb_alu_issue;

  localparam int unsigned DW = 16;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic [15:0]   instr = '0;
  logic          instr_ready;
  logic          alu_en;
  logic [2:0]    alu_func;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_imm;
  logic [DW-1:0] alu_res;
  logic          alu_res_en;
  logic          retire;
  logic          busy;
  logic          timeout_err;
  logic [2:0]    dbg_addr = '0;
  logic [DW-1:0] dbg_data;

  logic          alu_conn = 1'b1;
  logic          force_en = 1'b0;
  logic [DW-1:0] force_res = '0;
  logic          m_en;
  logic [DW-1:0] m_res;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int retires = 0;
  int acc_cyc[$];

  always #5 clk = ~clk;

  alu_issue #(.DWIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_en(alu_en), .alu_func(alu_func),
    .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm), .alu_res(alu_res),
    .alu_res_en(alu_res_en), .retire(retire), .busy(busy),
    .timeout_err(timeout_err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Single-cycle ALU model: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI, 5 ANDI, 6 ORI, 7 XOR.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_en  <= 1'b0;
      m_res <= '0;
    end else begin
      m_en <= alu_en;
      case (alu_func)
        3'd0:    m_res <= alu_a + alu_b;
        3'd1:    m_res <= alu_a - alu_b;
        3'd2:    m_res <= alu_a & alu_b;
        3'd3:    m_res <= alu_a | alu_b;
        3'd4:    m_res <= alu_a + alu_imm;
        3'd5:    m_res <= alu_a & alu_imm;
        3'd6:    m_res <= alu_a | alu_imm;
        default: m_res <= alu_a ^ alu_b;
      endcase
    end
  end

  assign alu_res_en = force_en | (alu_conn & m_en);
  assign alu_res    = force_en ? force_res : m_res;

  always @(posedge clk) begin
    if (rst_n && instr_valid && instr_ready) acc_cyc.push_back(cyc);
    if (retire) retires++;
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] w;
    logic [2:0]  rd;
    logic [15:0] a;
    logic [15:0] imm;
    logic [15:0] val;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [15:0] mk(input logic [2:0] f, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [6:0] lo);
    return {f, rd, rs1, lo};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic rd_reg(input logic [2:0] r, input logic [15:0] exp, input string name);
    dbg_addr = r;
    #1;
    check(name, 32'(dbg_data), 32'(exp));
  endtask

  // Present w at a negedge where instr_ready is high; it is accepted at the next posedge.
  task automatic send(input logic [15:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) check("ready_wait", 32'(instr_ready), 32'd1);
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  // Count negedges (starting at n_in) until retire is seen, bounded.
  task automatic wait_retire(input int n_in, output int n);
    n = n_in;
    while (!retire && n < 12) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    int low;
    int s0;
    int rc;

    vecs[0] = '{mk(3'd4, 3'd1, 3'd0, 7'h05), 3'd1, 16'h0000, 16'h0005, 16'h0005};
    vecs[1] = '{mk(3'd4, 3'd2, 3'd0, 7'h7F), 3'd2, 16'h0000, 16'hFFFF, 16'hFFFF};
    vecs[2] = '{mk(3'd1, 3'd3, 3'd1, 7'h20), 3'd3, 16'h0005, 16'h0020, 16'h0006};
    vecs[3] = '{mk(3'd5, 3'd4, 3'd1, 7'h04), 3'd4, 16'h0005, 16'h0004, 16'h0004};
    vecs[4] = '{mk(3'd3, 3'd5, 3'd4, 7'h20), 3'd5, 16'h0004, 16'h0020, 16'hFFFF};
    vecs[5] = '{mk(3'd0, 3'd0, 3'd1, 7'h10), 3'd0, 16'h0005, 16'h0010, 16'h0000};
    vecs[6] = '{mk(3'd7, 3'd6, 3'd1, 7'h30), 3'd6, 16'h0005, 16'h0030, 16'h0003};
    vecs[7] = '{mk(3'd6, 3'd7, 3'd0, 7'h40), 3'd7, 16'h0000, 16'hFFC0, 16'hFFC0};

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_en", 32'(alu_en), 32'd0);
    check("rst_tmo", 32'(timeout_err), 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    rd_reg(3'd3, 16'h0000, "rst_r3");

    // Table-driven single instructions with the ALU attached
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].w);
      @(negedge clk);
      check($sformatf("v%0d_alu_en", i), 32'(alu_en), 32'd1);
      check($sformatf("v%0d_alu_a", i), 32'(alu_a), 32'(vecs[i].a));
      check($sformatf("v%0d_alu_imm", i), 32'(alu_imm), 32'(vecs[i].imm));
      wait_retire(1, n);
      check($sformatf("v%0d_retire_lat", i), 32'(n), 32'd3);
      rd_reg(vecs[i].rd, vecs[i].val, $sformatf("v%0d_rf", i));
    end

    // Back-to-back issue with instr_valid held high
    s0 = acc_cyc.size();
    @(negedge clk);
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    instr = mk(3'd4, 3'd2, 3'd0, 7'h7F);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr = mk(3'd1, 3'd6, 3'd1, 7'h20);
    low = 0;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 12) begin
      low++;
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
    check("b2b_ready_low", 32'(low), 32'd2);
    check("b2b_accepts", 32'(acc_cyc.size() - s0), 32'd2);
    if (acc_cyc.size() >= s0 + 2)
      check("b2b_gap", 32'(acc_cyc[s0+1] - acc_cyc[s0]), 32'd3);
    @(negedge clk);
    wait_retire(1, n);
    check("b2b_retire_lat", 32'(n), 32'd3);
    rd_reg(3'd6, 16'h0006, "b2b_r6");

    // Result arriving on the final wait cycle wins over the timeout
    alu_conn = 1'b0;
    send(mk(3'd4, 3'd5, 3'd0, 7'h09));
    @(negedge clk);
    check("race_alu_en", 32'(alu_en), 32'd1);
    repeat (8) @(negedge clk);
    check("race_busy", 32'(busy), 32'd1);
    force_res = 16'h1234;
    force_en = 1'b1;
    @(posedge clk);
    #1 force_en = 1'b0;
    @(negedge clk);
    check("race_retire", 32'(retire), 32'd1);
    check("race_tmo", 32'(timeout_err), 32'd0);
    rd_reg(3'd5, 16'h1234, "race_r5");

    // Timeout with the ALU disconnected
    send(mk(3'd4, 3'd7, 3'd0, 7'h01));
    rc = retires;
    @(negedge clk);
    check("tmo_alu_en", 32'(alu_en), 32'd1);
    n = 0;
    while (!timeout_err && n < 20) begin
      @(negedge clk);
      n++;
    end
    // alu_en falls at the next edge; the error rises TO edges after that.
    check("tmo_lat", 32'(n), 32'(TO + 1));
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_ready", 32'(instr_ready), 32'd1);
    @(negedge clk);
    check("tmo_no_retire", 32'(retires - rc), 32'd0);
    rd_reg(3'd7, 16'hFFC0, "tmo_r7");
    alu_conn = 1'b1;
    send(mk(3'd4, 3'd7, 3'd0, 7'h02));
    @(negedge clk);
    wait_retire(1, n);
    check("tmo_next_lat", 32'(n), 32'd3);
    rd_reg(3'd7, 16'h0002, "tmo_next_r7");
    check("tmo_sticky", 32'(timeout_err), 32'd1);

    // Asynchronous reset in the middle of WAIT
    rd_reg(3'd1, 16'h0005, "prerst_r1");
    alu_conn = 1'b0;
    send(mk(3'd4, 3'd2, 3'd0, 7'h03));
    repeat (3) @(negedge clk);
    check("midwait_busy", 32'(busy), 32'd1);
    rc = retires;
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_tmo", 32'(timeout_err), 32'd0);
    check("arst_ready", 32'(instr_ready), 32'd1);
    check("arst_alu_en", 32'(alu_en), 32'd0);
    rd_reg(3'd1, 16'h0000, "arst_r1");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    force_res = 16'hBEEF;
    force_en = 1'b1;
    @(posedge clk);
    #1 force_en = 1'b0;
    repeat (2) @(negedge clk);
    check("late_res_retire", 32'(retires - rc), 32'd0);
    check("late_res_busy", 32'(busy), 32'd0);
    rd_reg(3'd2, 16'h0000, "late_res_r2");
    rd_reg(3'd0, 16'h0000, "late_res_r0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
